// File: rtl/banco_nos_pkg.sv
// Shared definitions for the active-node bank of the pathfinding engine:
// command opcodes, FSM states and the saturating criterion adder.
package banco_nos_pkg;

  localparam logic [1:0] OP_ATUALIZAR   = 2'b00;
  localparam logic [1:0] OP_REMOVER     = 2'b01;
  localparam logic [1:0] OP_EXTRAIR_MIN = 2'b10;
  localparam logic [1:0] OP_LIMPAR      = 2'b11;

  typedef enum logic {
    StOcioso,
    StRecalc
  } estado_t;

  // a + b clamped to the all-ones value of a largura-bit result
  function automatic logic [31:0] soma_saturada(input logic [31:0] a, input logic [31:0] b,
                                                input int unsigned largura);
    logic [32:0] soma;
    logic [32:0] limite;
    soma   = {1'b0, a} + {1'b0, b};
    limite = (33'd1 << largura) - 33'd1;
    if (soma > limite) begin
      return limite[31:0];
    end
    return soma[31:0];
  endfunction

endpackage

// File: rtl/banco_nos_ativos_if.sv
// Command/status bundle between the expansion controller (master) and the
// active-node bank (slave).
interface banco_nos_ativos_if #(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 8,
  parameter int unsigned CUSTO_WIDTH     = 4,
  parameter int unsigned CRITERIO_WIDTH  = 9,
  parameter int unsigned SLOT_WIDTH      = 3
);

  logic                       cmd_valid_in;
  logic [1:0]                 cmd_op_in;
  logic                       cmd_ready_out;
  logic [ADDR_WIDTH-1:0]      endereco_in;
  logic [ADDR_WIDTH-1:0]      anterior_in;
  logic [DISTANCIA_WIDTH-1:0] distancia_in;
  logic [CUSTO_WIDTH-1:0]     menor_vizinho_in;

  logic                       ba_min_valido_out;
  logic [ADDR_WIDTH-1:0]      ba_min_endereco_out;
  logic [DISTANCIA_WIDTH-1:0] ba_min_distancia_out;
  logic [ADDR_WIDTH-1:0]      ba_min_anterior_out;
  logic [CRITERIO_WIDTH-1:0]  ba_min_criterio_out;
  logic                       ba_extraido_out;
  logic                       ba_nova_menor_distancia_out;
  logic                       ba_estouro_out;
  logic                       ba_erro_out;
  logic [SLOT_WIDTH:0]        ba_ocupacao_out;
  logic                       ba_cheio_out;
  logic                       ba_vazio_out;

  modport master (
    output cmd_valid_in, cmd_op_in, endereco_in, anterior_in, distancia_in, menor_vizinho_in,
    input  cmd_ready_out, ba_min_valido_out, ba_min_endereco_out, ba_min_distancia_out,
           ba_min_anterior_out, ba_min_criterio_out, ba_extraido_out,
           ba_nova_menor_distancia_out, ba_estouro_out, ba_erro_out, ba_ocupacao_out,
           ba_cheio_out, ba_vazio_out
  );

  modport slave (
    input  cmd_valid_in, cmd_op_in, endereco_in, anterior_in, distancia_in, menor_vizinho_in,
    output cmd_ready_out, ba_min_valido_out, ba_min_endereco_out, ba_min_distancia_out,
           ba_min_anterior_out, ba_min_criterio_out, ba_extraido_out,
           ba_nova_menor_distancia_out, ba_estouro_out, ba_erro_out, ba_ocupacao_out,
           ba_cheio_out, ba_vazio_out
  );

endinterface

// File: rtl/seletor_menor_criterio.sv
// Combinational argmin over the slot criteria, restricted to valid slots.
// Strict less-than keeps the lowest index on ties.
module seletor_menor_criterio #(
  parameter int unsigned NUM_SLOTS      = 8,
  parameter int unsigned SLOT_WIDTH     = 3,
  parameter int unsigned CRITERIO_WIDTH = 9
) (
  input  logic [NUM_SLOTS-1:0][CRITERIO_WIDTH-1:0] criterios,
  input  logic [NUM_SLOTS-1:0]                     validos,
  output logic [SLOT_WIDTH-1:0]                    indice,
  output logic                                     achou
);

  logic [CRITERIO_WIDTH-1:0] melhor;

  always_comb begin
    achou  = 1'b0;
    indice = '0;
    melhor = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (validos[i] && (!achou || (criterios[i] < melhor))) begin
        achou  = 1'b1;
        indice = SLOT_WIDTH'(i);
        melhor = criterios[i];
      end
    end
  end

endmodule

// File: rtl/banco_nos_ativos.sv
// Open-set slot bank: insert-or-decrease, remove, extract-min and clear, with the
// minimum-criterion node re-registered one cycle after every accepted command.
module banco_nos_ativos
  import banco_nos_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned DISTANCIA_WIDTH = 8,
  parameter int unsigned CUSTO_WIDTH     = 4,
  parameter int unsigned CRITERIO_WIDTH  = 9,
  parameter int unsigned NUM_SLOTS       = 8,
  parameter int unsigned SLOT_WIDTH      = 3
) (
  input logic               clk,
  input logic               rst,
  banco_nos_ativos_if.slave bus
);

  localparam logic [SLOT_WIDTH:0] CHEIO = (SLOT_WIDTH + 1)'(NUM_SLOTS);

  estado_t                    estado_q;
  logic [NUM_SLOTS-1:0]       valido_q, valido_d;
  logic [ADDR_WIDTH-1:0]      endereco_q  [NUM_SLOTS];
  logic [ADDR_WIDTH-1:0]      anterior_q  [NUM_SLOTS];
  logic [DISTANCIA_WIDTH-1:0] distancia_q [NUM_SLOTS];
  logic [CUSTO_WIDTH-1:0]     vizinho_q   [NUM_SLOTS];

  logic [NUM_SLOTS-1:0][CRITERIO_WIDTH-1:0] criterio;
  logic [31:0]                soma;
  logic [SLOT_WIDTH-1:0]      sel_indice, hit_idx, livre_idx, escrita_idx;
  logic                       sel_achou, hit, livre, aceita, escreve, aloca;
  logic                       nova_d, estouro_d, erro_d, extraido_d;
  logic [SLOT_WIDTH:0]        ocupacao_d;

  logic                       ready_q, min_valido_q;
  logic [ADDR_WIDTH-1:0]      min_endereco_q, min_anterior_q;
  logic [DISTANCIA_WIDTH-1:0] min_distancia_q;
  logic [CRITERIO_WIDTH-1:0]  min_criterio_q;
  logic [SLOT_WIDTH-1:0]      min_slot_q;
  logic                       nova_q, estouro_q, erro_q, extraido_q, cheio_q, vazio_q;
  logic [SLOT_WIDTH:0]        ocupacao_q;

  assign aceita = bus.cmd_valid_in && (estado_q == StOcioso);

  // Invalid slots read as all-ones so they can never win the argmin.
  always_comb begin
    soma = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      soma = soma_saturada(32'(distancia_q[i]), 32'(vizinho_q[i]), CRITERIO_WIDTH);
      criterio[i] = valido_q[i] ? soma[CRITERIO_WIDTH-1:0] : '1;
    end
  end

  seletor_menor_criterio #(
    .NUM_SLOTS      (NUM_SLOTS),
    .SLOT_WIDTH     (SLOT_WIDTH),
    .CRITERIO_WIDTH (CRITERIO_WIDTH)
  ) u_seletor (
    .criterios (criterio),
    .validos   (valido_q),
    .indice    (sel_indice),
    .achou     (sel_achou)
  );

  always_comb begin
    hit       = 1'b0;
    hit_idx   = '0;
    livre     = 1'b0;
    livre_idx = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && valido_q[i] && (endereco_q[i] == bus.endereco_in)) begin
        hit     = 1'b1;
        hit_idx = SLOT_WIDTH'(i);
      end
      if (!livre && !valido_q[i]) begin
        livre     = 1'b1;
        livre_idx = SLOT_WIDTH'(i);
      end
    end
  end

  always_comb begin
    valido_d    = valido_q;
    escreve     = 1'b0;
    aloca       = 1'b0;
    escrita_idx = '0;
    nova_d      = 1'b0;
    estouro_d   = 1'b0;
    erro_d      = 1'b0;
    extraido_d  = 1'b0;
    if (aceita) begin
      case (bus.cmd_op_in)
        OP_ATUALIZAR: begin
          if (hit) begin
            if (bus.distancia_in < distancia_q[hit_idx]) begin
              escreve     = 1'b1;
              escrita_idx = hit_idx;
              nova_d      = 1'b1;
            end
          end else if (livre) begin
            escreve             = 1'b1;
            aloca               = 1'b1;
            escrita_idx         = livre_idx;
            valido_d[livre_idx] = 1'b1;
            nova_d              = 1'b1;
          end else begin
            estouro_d = 1'b1;
          end
        end
        OP_REMOVER: begin
          if (hit) valido_d[hit_idx] = 1'b0;
          else     erro_d = 1'b1;
        end
        OP_EXTRAIR_MIN: begin
          // Removes the slot currently shown on the min outputs.
          if (min_valido_q) begin
            valido_d[min_slot_q] = 1'b0;
            extraido_d           = 1'b1;
          end else begin
            erro_d = 1'b1;
          end
        end
        OP_LIMPAR: valido_d = '0;
        default: ;
      endcase
    end
    ocupacao_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      ocupacao_d = ocupacao_d + (SLOT_WIDTH + 1)'(valido_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (escreve) begin
      distancia_q[escrita_idx] <= bus.distancia_in;
      anterior_q[escrita_idx]  <= bus.anterior_in;
      if (aloca) begin
        endereco_q[escrita_idx] <= bus.endereco_in;
        vizinho_q[escrita_idx]  <= bus.menor_vizinho_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q        <= StOcioso;
      valido_q        <= '0;
      ready_q         <= 1'b1;
      min_valido_q    <= 1'b0;
      min_endereco_q  <= '0;
      min_distancia_q <= '0;
      min_anterior_q  <= '1;
      min_criterio_q  <= '1;
      min_slot_q      <= '0;
      nova_q          <= 1'b0;
      estouro_q       <= 1'b0;
      erro_q          <= 1'b0;
      extraido_q      <= 1'b0;
      ocupacao_q      <= '0;
      cheio_q         <= 1'b0;
      vazio_q         <= 1'b1;
    end else begin
      valido_q   <= valido_d;
      nova_q     <= nova_d;
      estouro_q  <= estouro_d;
      erro_q     <= erro_d;
      extraido_q <= extraido_d;
      ocupacao_q <= ocupacao_d;
      cheio_q    <= (ocupacao_d == CHEIO);
      vazio_q    <= (ocupacao_d == '0);
      case (estado_q)
        StOcioso: begin
          if (aceita) begin
            estado_q <= StRecalc;
            ready_q  <= 1'b0;
          end
        end
        StRecalc: begin
          estado_q     <= StOcioso;
          ready_q      <= 1'b1;
          min_valido_q <= sel_achou;
          min_slot_q   <= sel_achou ? sel_indice : '0;
          if (sel_achou) begin
            min_endereco_q  <= endereco_q[sel_indice];
            min_distancia_q <= distancia_q[sel_indice];
            min_anterior_q  <= anterior_q[sel_indice];
            min_criterio_q  <= criterio[sel_indice];
          end else begin
            min_endereco_q  <= '0;
            min_distancia_q <= '0;
            min_anterior_q  <= '1;
            min_criterio_q  <= '1;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready_out               = ready_q;
  assign bus.ba_min_valido_out           = min_valido_q;
  assign bus.ba_min_endereco_out         = min_endereco_q;
  assign bus.ba_min_distancia_out        = min_distancia_q;
  assign bus.ba_min_anterior_out         = min_anterior_q;
  assign bus.ba_min_criterio_out         = min_criterio_q;
  assign bus.ba_extraido_out             = extraido_q;
  assign bus.ba_nova_menor_distancia_out = nova_q;
  assign bus.ba_estouro_out              = estouro_q;
  assign bus.ba_erro_out                 = erro_q;
  assign bus.ba_ocupacao_out             = ocupacao_q;
  assign bus.ba_cheio_out                = cheio_q;
  assign bus.ba_vazio_out                = vazio_q;

endmodule

// File: tb/tb_banco_nos_ativos.sv
// Bench for banco_nos_ativos: slot-list reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_banco_nos_ativos;
  import banco_nos_pkg::*;

  localparam int AW = 5, DW = 8, CW = 4, RW = 9, NS = 8, SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banco_nos_ativos_if #(
    .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW), .CRITERIO_WIDTH(RW), .SLOT_WIDTH(SW)
  ) bus ();

  banco_nos_ativos #(
    .ADDR_WIDTH(AW), .DISTANCIA_WIDTH(DW), .CUSTO_WIDTH(CW), .CRITERIO_WIDTH(RW),
    .NUM_SLOTS(NS), .SLOT_WIDTH(SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, exp, $time);
    end
  endtask

  // Reference model: slot list plus the visible output state
  bit m_val[NS];
  int m_end[NS], m_dist[NS], m_ant[NS], m_viz[NS];
  bit m_recalc, e_ready, e_nova, e_est, e_erro, e_ext, e_mval;
  int e_ocup, e_mend, e_mdist, e_mant, e_mcrit, e_mslot, m_h, m_f, m_best;

  function automatic int crit_de(input int i);
    int c;
    c = m_dist[i] + m_viz[i];
    if (c > (1 << RW) - 1) c = (1 << RW) - 1;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) m_val[i] = 1'b0;
      m_recalc = 0; e_ready = 1; e_nova = 0; e_est = 0; e_erro = 0; e_ext = 0;
      e_ocup = 0; e_mval = 0; e_mend = 0; e_mdist = 0; e_mant = 31; e_mcrit = 511; e_mslot = 0;
    end else begin
      e_nova = 0; e_est = 0; e_erro = 0; e_ext = 0;
      if (m_recalc) begin
        m_best = -1;
        for (int i = 0; i < NS; i++)
          if (m_val[i] && (m_best < 0 || crit_de(i) < crit_de(m_best))) m_best = i;
        if (m_best >= 0) begin
          e_mval = 1; e_mend = m_end[m_best]; e_mdist = m_dist[m_best];
          e_mant = m_ant[m_best]; e_mcrit = crit_de(m_best); e_mslot = m_best;
        end else begin
          e_mval = 0; e_mend = 0; e_mdist = 0; e_mant = 31; e_mcrit = 511; e_mslot = 0;
        end
        m_recalc = 0; e_ready = 1;
      end else if (bus.cmd_valid_in && e_ready) begin
        m_h = -1; m_f = -1;
        for (int i = NS - 1; i >= 0; i--) begin
          if (m_val[i] && m_end[i] == int'(bus.endereco_in)) m_h = i;
          if (!m_val[i]) m_f = i;
        end
        case (bus.cmd_op_in)
          OP_ATUALIZAR: begin
            if (m_h >= 0) begin
              if (int'(bus.distancia_in) < m_dist[m_h]) begin
                m_dist[m_h] = int'(bus.distancia_in); m_ant[m_h] = int'(bus.anterior_in);
                e_nova = 1;
              end
            end else if (m_f >= 0) begin
              m_val[m_f] = 1; m_end[m_f] = int'(bus.endereco_in);
              m_dist[m_f] = int'(bus.distancia_in); m_ant[m_f] = int'(bus.anterior_in);
              m_viz[m_f] = int'(bus.menor_vizinho_in); e_nova = 1;
            end else e_est = 1;
          end
          OP_REMOVER: if (m_h >= 0) m_val[m_h] = 0; else e_erro = 1;
          OP_EXTRAIR_MIN: if (e_mval) begin m_val[e_mslot] = 0; e_ext = 1; end else e_erro = 1;
          default: for (int i = 0; i < NS; i++) m_val[i] = 0;
        endcase
        m_recalc = 1; e_ready = 0;
      end
      e_ocup = 0;
      for (int i = 0; i < NS; i++) e_ocup += int'(m_val[i]);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_ready", bus.cmd_ready_out, e_ready);
      chk("m_min_valido", bus.ba_min_valido_out, e_mval);
      chk("m_min_endereco", bus.ba_min_endereco_out, e_mend);
      chk("m_min_distancia", bus.ba_min_distancia_out, e_mdist);
      chk("m_min_anterior", bus.ba_min_anterior_out, e_mant);
      chk("m_min_criterio", bus.ba_min_criterio_out, e_mcrit);
      chk("m_extraido", bus.ba_extraido_out, e_ext);
      chk("m_nova_menor", bus.ba_nova_menor_distancia_out, e_nova);
      chk("m_estouro", bus.ba_estouro_out, e_est);
      chk("m_erro", bus.ba_erro_out, e_erro);
      chk("m_ocupacao", bus.ba_ocupacao_out, e_ocup);
      chk("m_cheio", bus.ba_cheio_out, e_ocup == NS);
      chk("m_vazio", bus.ba_vazio_out, e_ocup == 0);
    end
  end

  // Issues one command; returns at the falling edge of the cycle after acceptance.
  task automatic cmd(input logic [1:0] op, input int a, input int d, input int an, input int v,
                     input int ciclos = 1);
    int n = 0;
    while (bus.cmd_ready_out !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (n == 8) chk("ready_timeout", bus.cmd_ready_out, 1);
    bus.cmd_op_in        = op;
    bus.endereco_in      = a[AW-1:0];
    bus.distancia_in     = d[DW-1:0];
    bus.anterior_in      = an[AW-1:0];
    bus.menor_vizinho_in = v[CW-1:0];
    bus.cmd_valid_in     = 1'b1;
    repeat (ciclos) @(negedge clk);
    bus.cmd_valid_in = 1'b0;
  endtask

  initial begin
    bus.cmd_valid_in = 0; bus.cmd_op_in = 0; bus.endereco_in = 0;
    bus.distancia_in = 0; bus.anterior_in = 0; bus.menor_vizinho_in = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Reset state and extract on empty bank
    chk("t1_vazio", bus.ba_vazio_out, 1);
    chk("t1_ready", bus.cmd_ready_out, 1);
    chk("t1_min_valido", bus.ba_min_valido_out, 0);
    chk("t1_min_criterio", bus.ba_min_criterio_out, 9'h1FF);
    cmd(OP_EXTRAIR_MIN, 0, 0, 0, 0);
    chk("t1_erro", bus.ba_erro_out, 1);
    chk("t1_ready_low", bus.cmd_ready_out, 0);
    @(negedge clk);
    chk("t1_ready_back", bus.cmd_ready_out, 1);

    // Two allocations
    cmd(OP_ATUALIZAR, 3, 10, 1, 2);
    chk("t2_nova1", bus.ba_nova_menor_distancia_out, 1);
    cmd(OP_ATUALIZAR, 7, 5, 2, 1);
    chk("t2_nova2", bus.ba_nova_menor_distancia_out, 1);
    chk("t2_ocupacao", bus.ba_ocupacao_out, 2);
    @(negedge clk);
    chk("t2_min_end", bus.ba_min_endereco_out, 7);
    chk("t2_min_crit", bus.ba_min_criterio_out, 6);

    // Non-decrease is ignored, decrease applies
    cmd(OP_ATUALIZAR, 3, 12, 4, 0);
    chk("t3_nova_none", bus.ba_nova_menor_distancia_out, 0);
    @(negedge clk);
    chk("t3_min_kept", bus.ba_min_endereco_out, 7);
    cmd(OP_ATUALIZAR, 3, 2, 9, 0);
    chk("t3_nova", bus.ba_nova_menor_distancia_out, 1);
    @(negedge clk);
    chk("t3_min_end", bus.ba_min_endereco_out, 3);
    chk("t3_min_crit", bus.ba_min_criterio_out, 4);
    chk("t3_min_ant", bus.ba_min_anterior_out, 9);
    chk("t3_min_dist", bus.ba_min_distancia_out, 2);

    // Fill, overflow, decrease while full
    for (int k = 0; k < 6; k++) cmd(OP_ATUALIZAR, 10 + k, 20 + k, 0, 0);
    chk("t4_ocupacao", bus.ba_ocupacao_out, 8);
    chk("t4_cheio", bus.ba_cheio_out, 1);
    cmd(OP_ATUALIZAR, 20, 1, 0, 0);
    chk("t4_estouro", bus.ba_estouro_out, 1);
    chk("t4_ocupacao_full", bus.ba_ocupacao_out, 8);
    cmd(OP_ATUALIZAR, 12, 1, 4, 0);
    chk("t4_nova", bus.ba_nova_menor_distancia_out, 1);
    @(negedge clk);
    chk("t4_min_end", bus.ba_min_endereco_out, 12);
    chk("t4_min_crit", bus.ba_min_criterio_out, 1);
    chk("t4_min_ant", bus.ba_min_anterior_out, 4);

    // Tie between slots 2 and 5 (criterion 11)
    cmd(OP_LIMPAR, 0, 0, 0, 0);
    chk("t5_vazio", bus.ba_vazio_out, 1);
    cmd(OP_ATUALIZAR, 1, 50, 0, 0);
    cmd(OP_ATUALIZAR, 2, 40, 0, 0);
    cmd(OP_ATUALIZAR, 3, 8, 0, 3);
    cmd(OP_ATUALIZAR, 4, 30, 0, 0);
    cmd(OP_ATUALIZAR, 5, 35, 0, 0);
    cmd(OP_ATUALIZAR, 6, 10, 0, 1);
    @(negedge clk);
    chk("t5_min_end", bus.ba_min_endereco_out, 3);
    chk("t5_min_crit", bus.ba_min_criterio_out, 11);
    cmd(OP_EXTRAIR_MIN, 0, 0, 0, 0);
    chk("t5_extraido", bus.ba_extraido_out, 1);
    chk("t5_held_end", bus.ba_min_endereco_out, 3);
    chk("t5_held_dist", bus.ba_min_distancia_out, 8);
    @(negedge clk);
    chk("t5_next_end", bus.ba_min_endereco_out, 6);
    chk("t5_next_crit", bus.ba_min_criterio_out, 11);
    chk("t5_next_dist", bus.ba_min_distancia_out, 10);

    // Remove miss/hit, clear, held request, reset during recalc
    cmd(OP_REMOVER, 31, 0, 0, 0);
    chk("t6_erro_miss", bus.ba_erro_out, 1);
    cmd(OP_REMOVER, 1, 0, 0, 0);
    chk("t6_erro_hit", bus.ba_erro_out, 0);
    chk("t6_ocupacao", bus.ba_ocupacao_out, 4);
    cmd(OP_LIMPAR, 0, 0, 0, 0);
    chk("t6_vazio", bus.ba_vazio_out, 1);
    chk("t6_ocupacao0", bus.ba_ocupacao_out, 0);
    cmd(OP_ATUALIZAR, 9, 7, 0, 0, 2);
    chk("t6_held_ocup", bus.ba_ocupacao_out, 1);
    cmd(OP_ATUALIZAR, 9, 3, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_vazio", bus.ba_vazio_out, 1);
    chk("t6_rst_ready", bus.cmd_ready_out, 1);
    chk("t6_rst_valido", bus.ba_min_valido_out, 0);
    chk("t6_rst_ant", bus.ba_min_anterior_out, 5'h1F);
    chk("t6_rst_crit", bus.ba_min_criterio_out, 9'h1FF);
    chk("t6_rst_ocup", bus.ba_ocupacao_out, 0);
    chk("t6_rst_nova", bus.ba_nova_menor_distancia_out, 0);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
